// File: rtl/timer_pkg.sv
// Shared definitions for periph_timer: register offsets, bit positions,
// reset values and the run-state encoding.
package timer_pkg;

  localparam logic [4:0] OFF_TCR  = 5'h00;
  localparam logic [4:0] OFF_PSC  = 5'h04;
  localparam logic [4:0] OFF_ARR  = 5'h08;
  localparam logic [4:0] OFF_CNT  = 5'h0C;
  localparam logic [4:0] OFF_SR   = 5'h10;
  localparam logic [4:0] OFF_CAPR = 5'h14;

  localparam int TCR_EN      = 0;
  localparam int TCR_CLR     = 1;
  localparam int TCR_ONESHOT = 2;
  localparam int TCR_IE      = 3;
  localparam int SR_UIF      = 0;
  localparam int SR_CCIF     = 1;

  localparam logic [15:0] PSC_RST  = 16'h0000;
  localparam logic [31:0] ARR_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] CNT_RST  = 32'h0000_0000;
  localparam logic [31:0] CAPR_RST = 32'h0000_0000;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  function automatic logic [4:0] reg_offset(input logic [2:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 16-bit prescaler: one-cycle tick every psc+1 cycles while enabled. A new
// psc value is only adopted when the count restarts.
module timer_prescaler (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] psc,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] psc_act_q, psc_act_d;

  assign tick = en & (cnt_q == psc_act_q);

  always_comb begin
    cnt_d     = cnt_q;
    psc_act_d = psc_act_q;
    if (!en || clr) begin
      cnt_d     = 16'h0000;
      psc_act_d = psc;
    end else if (cnt_q == psc_act_q) begin
      cnt_d     = 16'h0000;
      psc_act_d = psc;
    end else begin
      cnt_d     = cnt_q + 16'h0001;
      psc_act_d = psc_act_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cnt_q     <= 16'h0000;
      psc_act_q <= 16'h0000;
    end else begin
      cnt_q     <= cnt_d;
      psc_act_q <= psc_act_d;
    end
  end

endmodule

// File: rtl/periph_timer.sv
// APB3 zero-wait-state 32-bit timer with prescaler, auto-reload and one-shot.
// Optional input capture channel is built when TIMER_CAPTURE_EN is defined.
module periph_timer
  import timer_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        cap_in,
  output logic        irq
);

  logic        acc_s, wr_s, rd_s;
  logic [4:0]  offset_s;
  logic        wr_tcr_s, wr_psc_s, wr_arr_s, wr_cnt_s, wr_sr_s;
  state_e      state_q, state_d;
  logic        oneshot_q, oneshot_d, ie_q, ie_d;
  logic        uif_q, uif_d, irq_q, irq_d;
  logic [15:0] psc_q, psc_d;
  logic [31:0] arr_q, arr_d, cnt_q, cnt_d;
  logic        tick_s, clr_s, tick_eff_s, wrap_s;
  logic        ccif_s;
  logic [31:0] capr_s;
  logic [31:0] prdata_s;
  logic        unused_s;

  assign acc_s    = PSEL & PENABLE;
  assign wr_s     = acc_s & PWRITE;
  assign rd_s     = acc_s & ~PWRITE;
  assign offset_s = reg_offset(PADDR[4:2]);
  assign wr_tcr_s = wr_s & (offset_s == OFF_TCR);
  assign wr_psc_s = wr_s & (offset_s == OFF_PSC);
  assign wr_arr_s = wr_s & (offset_s == OFF_ARR);
  assign wr_cnt_s = wr_s & (offset_s == OFF_CNT);
  assign wr_sr_s  = wr_s & (offset_s == OFF_SR);
  assign clr_s    = wr_tcr_s & PWDATA[TCR_CLR];

  timer_prescaler u_prescaler (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .en     (state_q == RUNNING),
    .clr    (clr_s),
    .psc    (psc_q),
    .tick   (tick_s)
  );

  // A tick is dropped when software writes CNT, pulses CLR or clears EN in the same cycle.
  assign tick_eff_s = tick_s & ~clr_s & ~wr_cnt_s & ~(wr_tcr_s & ~PWDATA[TCR_EN]);
  assign wrap_s     = tick_eff_s & (cnt_q >= arr_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: begin
        if (wr_tcr_s && PWDATA[TCR_EN]) state_d = RUNNING;
        else                            state_d = STOPPED;
      end
      RUNNING: begin
        if (wr_tcr_s)                   state_d = PWDATA[TCR_EN] ? RUNNING : STOPPED;
        else if (wrap_s && oneshot_q)   state_d = STOPPED;
        else                            state_d = RUNNING;
      end
      default: state_d = STOPPED;
    endcase
  end

  always_comb begin
    oneshot_d = wr_tcr_s ? PWDATA[TCR_ONESHOT] : oneshot_q;
    ie_d      = wr_tcr_s ? PWDATA[TCR_IE] : ie_q;
    psc_d     = wr_psc_s ? PWDATA[15:0] : psc_q;
    arr_d     = wr_arr_s ? PWDATA : arr_q;
    if (wr_cnt_s)        cnt_d = PWDATA;
    else if (clr_s)      cnt_d = CNT_RST;
    else if (wrap_s)     cnt_d = 32'h0000_0000;
    else if (tick_eff_s) cnt_d = cnt_q + 32'h0000_0001;
    else                 cnt_d = cnt_q;
    uif_d = wrap_s | (uif_q & ~(wr_sr_s & PWDATA[SR_UIF]));
    irq_d = ie_q & uif_q;
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q   <= STOPPED;
      oneshot_q <= 1'b0;
      ie_q      <= 1'b0;
      psc_q     <= PSC_RST;
      arr_q     <= ARR_RST;
      cnt_q     <= CNT_RST;
      uif_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
      psc_q     <= psc_d;
      arr_q     <= arr_d;
      cnt_q     <= cnt_d;
      uif_q     <= uif_d;
      irq_q     <= irq_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic        cap_sync1_q, cap_sync2_q, cap_prev_q, cap_rise_s;
  logic        ccif_q, ccif_d;
  logic [31:0] capr_q, capr_d;

  assign cap_rise_s = cap_sync2_q & ~cap_prev_q;

  always_comb begin
    capr_d = cap_rise_s ? cnt_q : capr_q;
    ccif_d = cap_rise_s | (ccif_q & ~(wr_sr_s & PWDATA[SR_CCIF]));
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cap_sync1_q <= 1'b0;
      cap_sync2_q <= 1'b0;
      cap_prev_q  <= 1'b0;
      ccif_q      <= 1'b0;
      capr_q      <= CAPR_RST;
    end else begin
      cap_sync1_q <= cap_in;
      cap_sync2_q <= cap_sync1_q;
      cap_prev_q  <= cap_sync2_q;
      ccif_q      <= ccif_d;
      capr_q      <= capr_d;
    end
  end

  assign ccif_s   = ccif_q;
  assign capr_s   = capr_q;
  assign unused_s = ^{PADDR[31:5], PADDR[1:0]};
`else
  assign ccif_s   = 1'b0;
  assign capr_s   = CAPR_RST;
  assign unused_s = ^{cap_in, PADDR[31:5], PADDR[1:0]};
`endif

  always_comb begin
    prdata_s = 32'h0000_0000;
    if (rd_s) begin
      case (offset_s)
        OFF_TCR:  prdata_s = {28'h0000000, ie_q, oneshot_q, 1'b0, (state_q == RUNNING)};
        OFF_PSC:  prdata_s = {16'h0000, psc_q};
        OFF_ARR:  prdata_s = arr_q;
        OFF_CNT:  prdata_s = cnt_q;
        OFF_SR:   prdata_s = {30'h00000000, ccif_s, uif_q};
        OFF_CAPR: prdata_s = capr_s;
        default:  prdata_s = 32'h0000_0000;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  assign PRDATA = prdata_s;
  assign PREADY = acc_s;
  assign irq    = irq_q;

endmodule

// File: tb/tb_periph_timer.sv
// Directed self-checking bench for periph_timer (APB register access, counting,
// one-shot, flag priority, prescaler reload, reset and optional capture).
module tb_periph_timer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [31:0] PADDR = 32'h0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        cap_in = 1'b0;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int base = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  periph_timer dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .cap_in  (cap_in),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Samples state registered at the edge after the setup phase.
  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    v = PRDATA;
    check({tag, "_pready"}, {31'h0, PREADY}, 32'h1);
    check(tag, v, exp);
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic sync_to(input int e);
    while (cyc < e) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("idle_prdata", PRDATA, 32'h0);
    check("idle_pready", {31'h0, PREADY}, 32'h0);
    read_chk("rst_tcr", 32'h00, 32'h0);
    read_chk("rst_psc", 32'h04, 32'h0);
    read_chk("rst_arr", 32'h08, 32'hFFFF_FFFF);
    read_chk("rst_cnt", 32'h0C, 32'h0);
    read_chk("rst_sr", 32'h10, 32'h0);
    read_chk("rst_capr", 32'h14, 32'h0);
    read_chk("rst_unmapped", 32'h18, 32'h0);

    // Read-only / unmapped writes are ignored; PSC is 16 bits wide.
    apb_write(32'h14, 32'h0000_1234);
    apb_write(32'h1C, 32'hFFFF_FFFF);
    apb_write(32'h04, 32'hABCD_1234);
    read_chk("capr_ro", 32'h14, 32'h0);
    read_chk("unmapped_wr", 32'h1C, 32'h0);
    read_chk("psc_width", 32'h04, 32'h0000_1234);

    // Free-running PSC=3 ARR=4: update every 20 cycles, irq one cycle later.
    apb_write(32'h04, 32'd3);
    apb_write(32'h08, 32'd4);
    apb_write(32'h00, 32'h9);
    base = cyc;
    sync_to(base + 3);
    read_chk("cnt_e4", 32'h0C, 32'd1);
    sync_to(base + 11);
    read_chk("cnt_e12", 32'h0C, 32'd3);
    sync_to(base + 20);
    check("irq_e20", {31'h0, irq}, 32'h0);
    sync_to(base + 21);
    check("irq_e21", {31'h0, irq}, 32'h1);
    apb_write(32'h10, 32'h1);
    sync_to(base + 30);
    check("irq_e30", {31'h0, irq}, 32'h0);
    sync_to(base + 40);
    check("irq_e40", {31'h0, irq}, 32'h0);
    sync_to(base + 41);
    check("irq_e41", {31'h0, irq}, 32'h1);
    apb_write(32'h00, 32'h2);
    apb_write(32'h10, 32'h1);
    read_chk("sr_cleared", 32'h10, 32'h0);
    read_chk("cnt_clr_stopped", 32'h0C, 32'h0);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // One-shot: three ticks then stop with CNT=0.
    apb_write(32'h04, 32'd0);
    apb_write(32'h08, 32'd2);
    apb_write(32'h00, 32'h5);
    base = cyc;
    sync_to(base + 1);
    read_chk("os_cnt_e2", 32'h0C, 32'd2);
    sync_to(base + 3);
    read_chk("os_tcr", 32'h00, 32'h4);
    sync_to(base + 5);
    read_chk("os_cnt_hold", 32'h0C, 32'd0);
    read_chk("os_uif", 32'h10, 32'h1);
    apb_write(32'h10, 32'h1);

    // Clearing EN in the cycle of a tick discards that tick.
    apb_write(32'h00, 32'h1);
    apb_write(32'h00, 32'h0);
    read_chk("en0_tick_drop", 32'h0C, 32'd1);

    // CNT write beats a wrapping tick and suppresses its UIF.
    apb_write(32'h08, 32'd50);
    apb_write(32'h0C, 32'd49);
    apb_write(32'h00, 32'h1);
    apb_write(32'h0C, 32'd7);
    read_chk("cntwr_no_uif", 32'h10, 32'h0);
    read_chk("cntwr_value", 32'h0C, 32'd10);
    apb_write(32'h00, 32'h3);
    read_chk("clr_reads0", 32'h00, 32'h1);
    read_chk("clr_cnt", 32'h0C, 32'd3);
    apb_write(32'h00, 32'h0);

    // ARR dropped below CNT forces a wrap; PSC change waits for restart.
    apb_write(32'h04, 32'd9);
    apb_write(32'h0C, 32'd10);
    apb_write(32'h08, 32'hFFFF_FFFF);
    apb_write(32'h00, 32'h1);
    base = cyc;
    apb_write(32'h08, 32'd5);
    sync_to(base + 8);
    read_chk("arr_cnt_before", 32'h0C, 32'd10);
    sync_to(base + 10);
    read_chk("arr_uif", 32'h10, 32'h1);
    sync_to(base + 12);
    read_chk("arr_cnt_wrap", 32'h0C, 32'd0);
    apb_write(32'h04, 32'd1);
    sync_to(base + 19);
    read_chk("psc_old_period", 32'h0C, 32'd1);
    sync_to(base + 23);
    read_chk("psc_new_period", 32'h0C, 32'd3);
    apb_write(32'h00, 32'h2);
    apb_write(32'h10, 32'h3);

    // Hardware UIF set wins over a simultaneous W1C.
    apb_write(32'h04, 32'd0);
    apb_write(32'h08, 32'd0);
    apb_write(32'h00, 32'h9);
    base = cyc;
    apb_write(32'h10, 32'h1);
    check("w1c_irq_e2", {31'h0, irq}, 32'h1);
    sync_to(base + 3);
    check("w1c_irq_e3", {31'h0, irq}, 32'h1);
    read_chk("w1c_uif", 32'h10, 32'h1);

    // Asynchronous reset mid-run.
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    check("arst_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("arst_irq_after", {31'h0, irq}, 32'h0);
    read_chk("arst_tcr", 32'h00, 32'h0);
    read_chk("arst_arr", 32'h08, 32'hFFFF_FFFF);
    read_chk("arst_cnt", 32'h0C, 32'h0);
    read_chk("arst_sr", 32'h10, 32'h0);

    // Capture: edge seen three cycles later with the CNT of the detect cycle.
    apb_write(32'h00, 32'h1);
    @(negedge PCLK);
    cap_in = 1'b1;
`ifdef TIMER_CAPTURE_EN
    read_chk("cap_sr_early", 32'h10, 32'h0);
    read_chk("cap_capr", 32'h14, 32'd2);
    read_chk("cap_ccif", 32'h10, 32'h2);
    apb_write(32'h10, 32'h2);
    read_chk("cap_ccif_clr", 32'h10, 32'h0);
`else
    read_chk("nocap_sr_early", 32'h10, 32'h0);
    read_chk("nocap_capr", 32'h14, 32'h0);
    read_chk("nocap_sr", 32'h10, 32'h0);
`endif
    apb_write(32'h00, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
